pipelined_datapath: RTL and testbench
=====================================

Name: pipelined_datapath

Overview:
Parametrised two-stage register-file + ALU datapath: successor to the 4-bit, 4-register microprocessor core.
- Generalised in data width and register count.
- Adds a valid/ready instruction handshake, an immediate load, carry-chained ops and an iterative multiplier that back-pressures issue.
- Includes a registered flags unit and write-back forwarding.
- Sits between the instruction sequencer (upstream) and result consumers/debug logic (downstream).

Parameters:
DATA_W, 8, operand/register/result width (>=4)
NUM_REGS, 8, number of general registers (power of 2, >=2)
SEL_W, $clog2(NUM_REGS), register-select width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  datapath can accept this cycle
opcode  in  4  operation
read_sel1  in  SEL_W  operand1 register
read_sel2  in  SEL_W  operand2 register
write_sel  in  SEL_W  destination register
imm  in  DATA_W  immediate for LDI
result  out  DATA_W  last completed result (registered)
result_valid  out  1  one-cycle pulse per completed non-NOP op
zero_flag  out  1  registered Z
carry_flag  out  1  registered C
dbg_sel  in  SEL_W  debug read select
dbg_data  out  DATA_W  combinational read of register dbg_sel

Behaviour:
- Reset (sync, active-high): all registers, result, flags, result_valid = 0; EX stage empty; multiplier idle. instr_ready = 0 while reset is high, 1 in the first cycle after. Reset mid-multiply aborts it: no write, no pulse.
- Accept = instr_valid & instr_ready at a rising edge. At the accept edge, operands are read and captured into ID/EX.
- Bypass: if the op leaving EX on the same edge writes register R, and read_sel1/2 == R, capture that op's ALU output instead of the register-file value.
- Single-cycle ops: accepted at edge k; result, flags and register write occur at edge k+1; result_valid is high for the cycle after k+1. Throughput is 1 op/cycle.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(op1), 6 SHL(op1,1), 7 SHR(op1,1), 8 ADC (op1+op2+C), 9 SBB (op1-op2-C), A INC(op1), B LDI(imm), C MOV(op1), D MUL, E CMP, F NOP.
- Arithmetic is DATA_W-bit wrap-around.
- C rules:
  - ADD/ADC/INC: C = carry out of bit DATA_W-1.
  - SUB/SBB/CMP: C = borrow.
  - SHL/SHR: C = bit shifted out.
  - MUL: C = high half of full product nonzero.
  - Logic, LDI, MOV: C = 0.
- Z = (result == 0) for every op except NOP.
- ADC/SBB use the flags register value at the moment the op is in EX. Flags from the immediately preceding op are visible with no hazard.
- CMP updates flags, result and result_valid, but does not write a register.
- NOP: no write, no pulse; flags and result unchanged.
- MUL (shift-add, low DATA_W bits of the product):
  - Accepted at edge k; completes at edge k+DATA_W.
  - instr_ready = 0 for the DATA_W-1 cycles after edge k. It returns to 1 in the final iteration cycle, so the next op can be accepted at edge k+DATA_W, with bypass applied.
  - The upstream must hold its instruction stable while instr_ready = 0.
- Write to the register read by the same instruction: the new value is seen only by later instructions.
- dbg_data reflects register contents after the edge; it does not bypass.

Decomposition:
- Package datapath_pkg:
  - opcode enum (OP_ADD…OP_NOP).
  - function op_writes_reg(opcode): false for CMP/NOP.
  - function op_is_multicycle(opcode).
- Sub-module register_file_p (DATA_W, NUM_REGS): sync-reset array, 2 read ports + debug read port, 1 write port. The bypass mux lives in the parent.
- Multiplier FSM (IDLE/RUN, counter 0..DATA_W-1) stays inline in the parent.

Test Plan:
1. Reset; back-to-back LDI r1=0xF0, LDI r2=0x20, ADD r3=r1+r2 (r2 via bypass) -> result 0x10, C=1, Z=0, dbg r3=0x10; three consecutive result_valid pulses.
2. Immediately ADC r4=r1+r2 -> 0x11, C=1. Then SUB r5=r2-r1 -> 0x30, C=1. Then CMP r1,r1 -> Z=1, C=0, no register written (dbg r0..r7 unchanged).
3. LDI r1=0x0F, LDI r2=0x11, MUL r6 with the next ADD held valid -> instr_ready low exactly 7 cycles; r6=0xFF, C=0; the ADD is accepted at the MUL completion edge and uses forwarded r6.
4. MUL 0x10*0x10 -> result 0x00, Z=1, C=1.
5. Assert reset 3 cycles into a MUL -> no write, result_valid never pulses, all registers/flags 0, instr_ready 0 during reset then 1.
6. LDI r1=0x81; SHL r2=r1 -> 0x02, C=1; SHR r3=r1 -> 0x40, C=1; NOP -> no pulse, flags unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - opcode encoding and opcode classification helpers for the datapath
package datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_ADC = 4'h8,
    OP_SBB = 4'h9,
    OP_INC = 4'hA,
    OP_LDI = 4'hB,
    OP_MOV = 4'hC,
    OP_MUL = 4'hD,
    OP_CMP = 4'hE,
    OP_NOP = 4'hF
  } opcode_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

  function automatic logic op_writes_reg(input opcode_t op);
    return !(op == OP_CMP || op == OP_NOP);
  endfunction

  function automatic logic op_is_multicycle(input opcode_t op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/register_file_p.sv
// rtl/register_file_p.sv - sync-reset register array with two read ports, a debug read port and one write port
module register_file_p
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  i_rd_sel1,
  output logic [DATA_W-1:0] o_rd_data1,
  input  logic [SEL_W-1:0]  i_rd_sel2,
  output logic [DATA_W-1:0] o_rd_data2,
  input  logic [SEL_W-1:0]  i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_wr_en,
  input  logic [SEL_W-1:0]  i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_wr_en) begin
      r_regs[i_wr_sel] <= i_wr_data;
    end
  end

  assign o_rd_data1 = r_regs[i_rd_sel1];
  assign o_rd_data2 = r_regs[i_rd_sel2];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage register-file + ALU datapath with forwarding and iterative multiplier
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [SEL_W-1:0]  read_sel1,
  input  logic [SEL_W-1:0]  read_sel2,
  input  logic [SEL_W-1:0]  write_sel,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              zero_flag,
  output logic              carry_flag,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  opcode_t           w_op;
  logic              w_accept;
  logic [DATA_W-1:0] w_rf_rd1, w_rf_rd2, w_op1, w_op2;

  logic              r_ex_valid;
  opcode_t           r_ex_op;
  logic [DATA_W-1:0] r_ex_a, r_ex_b;
  logic [SEL_W-1:0]  r_ex_wsel;

  mul_state_t          r_mul_state, w_mul_state_next;
  logic [CNT_W-1:0]    r_mul_cnt;
  logic [2*DATA_W-1:0] r_mul_acc, r_mul_mcand, w_mul_acc_next;
  logic [DATA_W-1:0]   r_mul_mplier;
  logic                w_mul_busy, w_mul_done;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_ex_done, w_wb_we;

  logic [DATA_W-1:0] r_result;
  logic              r_result_valid, r_z, r_c;

  assign w_op     = opcode_t'(opcode);
  assign w_accept = instr_valid & instr_ready;

  register_file_p #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .SEL_W   (SEL_W)
  ) u_rf (
    .clk       (clk),
    .reset     (reset),
    .i_rd_sel1 (read_sel1),
    .o_rd_data1(w_rf_rd1),
    .i_rd_sel2 (read_sel2),
    .o_rd_data2(w_rf_rd2),
    .i_dbg_sel (dbg_sel),
    .o_dbg_data(dbg_data),
    .i_wr_en   (w_wb_we),
    .i_wr_sel  (r_ex_wsel),
    .i_wr_data (w_alu_res)
  );

  // Forward the op retiring on this edge so back-to-back dependents see its result.
  assign w_op1 = (w_wb_we && r_ex_wsel == read_sel1) ? w_alu_res : w_rf_rd1;
  assign w_op2 = (w_wb_we && r_ex_wsel == read_sel2) ? w_alu_res : w_rf_rd2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_state <= MUL_IDLE;
    end else begin
      r_mul_state <= w_mul_state_next;
    end
  end

  always_comb begin
    w_mul_state_next = r_mul_state;
    case (r_mul_state)
      MUL_IDLE: if (w_accept && op_is_multicycle(w_op)) w_mul_state_next = MUL_RUN;
      MUL_RUN: begin
        if (w_accept && op_is_multicycle(w_op)) w_mul_state_next = MUL_RUN;
        else if (r_mul_cnt == LAST_CNT)         w_mul_state_next = MUL_IDLE;
      end
      default: w_mul_state_next = MUL_IDLE;
    endcase
  end

  // Issue reopens during the last iteration so the next op lands on the completion edge.
  always_comb begin
    w_mul_busy = 1'b0;
    w_mul_done = 1'b0;
    if (r_mul_state == MUL_RUN) begin
      w_mul_busy = (r_mul_cnt != LAST_CNT);
      w_mul_done = (r_mul_cnt == LAST_CNT);
    end
  end

  assign w_mul_acc_next = r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_cnt    <= '0;
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
    end else if (w_accept && op_is_multicycle(w_op)) begin
      r_mul_cnt    <= '0;
      r_mul_acc    <= '0;
      r_mul_mcand  <= {{DATA_W{1'b0}}, w_op1};
      r_mul_mplier <= w_op2;
    end else if (r_mul_state == MUL_RUN && !w_mul_done) begin
      r_mul_cnt    <= r_mul_cnt + 1'b1;
      r_mul_acc    <= w_mul_acc_next;
      r_mul_mcand  <= r_mul_mcand << 1;
      r_mul_mplier <= r_mul_mplier >> 1;
    end
  end

  assign instr_ready = !reset && !w_mul_busy;
  assign w_ex_done   = r_ex_valid && (!op_is_multicycle(r_ex_op) || w_mul_done);
  assign w_wb_we     = w_ex_done && op_writes_reg(r_ex_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= OP_NOP;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_wsel  <= '0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_ex_op    <= w_op;
      r_ex_a     <= w_op1;
      r_ex_b     <= (w_op == OP_LDI) ? imm : w_op2;
      r_ex_wsel  <= write_sel;
    end else if (w_ex_done) begin
      r_ex_valid <= 1'b0;
    end
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (r_ex_op)
      OP_ADD: {w_alu_c, w_alu_res} = {1'b0, r_ex_a} + {1'b0, r_ex_b};
      OP_ADC: {w_alu_c, w_alu_res} = {1'b0, r_ex_a} + {1'b0, r_ex_b} + {{DATA_W{1'b0}}, r_c};
      OP_SUB, OP_CMP: {w_alu_c, w_alu_res} = {1'b0, r_ex_a} - {1'b0, r_ex_b};
      OP_SBB: {w_alu_c, w_alu_res} = {1'b0, r_ex_a} - {1'b0, r_ex_b} - {{DATA_W{1'b0}}, r_c};
      OP_INC: {w_alu_c, w_alu_res} = {1'b0, r_ex_a} + (DATA_W + 1)'(1);
      OP_AND: w_alu_res = r_ex_a & r_ex_b;
      OP_OR:  w_alu_res = r_ex_a | r_ex_b;
      OP_XOR: w_alu_res = r_ex_a ^ r_ex_b;
      OP_NOT: w_alu_res = ~r_ex_a;
      OP_SHL: begin
        w_alu_res = {r_ex_a[DATA_W-2:0], 1'b0};
        w_alu_c   = r_ex_a[DATA_W-1];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, r_ex_a[DATA_W-1:1]};
        w_alu_c   = r_ex_a[0];
      end
      OP_LDI: w_alu_res = r_ex_b;
      OP_MOV: w_alu_res = r_ex_a;
      OP_MUL: begin
        w_alu_res = w_mul_acc_next[DATA_W-1:0];
        w_alu_c   = |w_mul_acc_next[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_z            <= 1'b0;
      r_c            <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_ex_done && r_ex_op != OP_NOP) begin
        r_result       <= w_alu_res;
        r_result_valid <= 1'b1;
        r_z            <= (w_alu_res == '0);
        r_c            <= w_alu_c;
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign zero_flag    = r_z;
  assign carry_flag   = r_c;

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - directed scoreboard bench for pipelined_datapath
`timescale 1ns/100ps
module tb_pipelined_datapath;
  import datapath_pkg::*;

  localparam int DW = 8;
  localparam int NR = 8;
  localparam int SW = 3;

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    logic          c;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    opcode;
  logic [SW-1:0] read_sel1, read_sel2, write_sel, dbg_sel;
  logic [DW-1:0] imm, result, dbg_data;
  logic          result_valid, zero_flag, carry_flag;

  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            low_cnt;
  exp_t          sb[$];
  int            pulse_cyc[$];
  logic [DW-1:0] m_regs [NR];

  always #5 clk = ~clk;

  pipelined_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .read_sel1   (read_sel1),
    .read_sel2   (read_sel2),
    .write_sel   (write_sel),
    .imm         (imm),
    .result      (result),
    .result_valid(result_valid),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (result_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, result_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {24'd0, result}, {24'd0, e.res});
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
      end
    end
  endtask

  task automatic issue(input opcode_t op, input int s1, input int s2, input int wd,
                       input logic [DW-1:0] im, input logic [DW-1:0] er,
                       input logic ez, input logic ec, input bit push, output int lowcnt);
    exp_t e;
    instr_valid = 1'b1;
    opcode      = op;
    read_sel1   = SW'(s1);
    read_sel2   = SW'(s2);
    write_sel   = SW'(wd);
    imm         = im;
    if (push && op != OP_NOP) begin
      e.res = er;
      e.z   = ez;
      e.c   = ec;
      sb.push_back(e);
      if (op != OP_CMP) m_regs[wd] = er;
    end
    lowcnt = 0;
    while (instr_ready !== 1'b1 && lowcnt < 64) begin
      tick();
      lowcnt++;
    end
    if (lowcnt >= 64) chk("issue_timeout", {31'd0, instr_ready}, 32'd1);
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    instr_valid = 1'b0;
    opcode      = OP_NOP;
    while (sb.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  task automatic check_regs();
    for (int i = 0; i < NR; i++) begin
      dbg_sel = SW'(i);
      tick();
      chk($sformatf("dbg_r%0d", i), {24'd0, dbg_data}, {24'd0, m_regs[i]});
    end
  endtask

  task automatic check_cleared();
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_zero", {31'd0, zero_flag}, 32'd0);
    chk("rst_carry", {31'd0, carry_flag}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    opcode      = OP_NOP;
    read_sel1   = '0;
    read_sel2   = '0;
    write_sel   = '0;
    imm         = '0;
    dbg_sel     = '0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
    check_cleared();
    check_regs();
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    // Back-to-back chain with forwarding, carry chaining and CMP
    pulse_cyc.delete();
    issue(OP_LDI, 0, 0, 1, 8'hF0, 8'hF0, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_LDI, 0, 0, 2, 8'h20, 8'h20, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_ADD, 1, 2, 3, 8'h00, 8'h10, 1'b0, 1'b1, 1, low_cnt);
    issue(OP_ADC, 1, 2, 4, 8'h00, 8'h11, 1'b0, 1'b1, 1, low_cnt);
    issue(OP_SUB, 2, 1, 5, 8'h00, 8'h30, 1'b0, 1'b1, 1, low_cnt);
    issue(OP_CMP, 1, 1, 7, 8'h00, 8'h00, 1'b1, 1'b0, 1, low_cnt);
    drain();
    chk("chain_pulses", pulse_cyc.size(), 32'd6);
    if (pulse_cyc.size() >= 6) chk("chain_consecutive", pulse_cyc[5] - pulse_cyc[0], 32'd5);
    chk("cmp_zero", {31'd0, zero_flag}, 32'd1);
    chk("cmp_carry", {31'd0, carry_flag}, 32'd0);
    check_regs();

    // MUL back-pressure with a dependent op held at the input
    pulse_cyc.delete();
    issue(OP_LDI, 0, 0, 1, 8'h0F, 8'h0F, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_LDI, 0, 0, 2, 8'h11, 8'h11, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_MUL, 1, 2, 6, 8'h00, 8'hFF, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_ADD, 6, 2, 7, 8'h00, 8'h10, 1'b0, 1'b1, 1, low_cnt);
    chk("mul_ready_low_cycles", low_cnt, 32'd7);
    drain();
    chk("mul_pulses", pulse_cyc.size(), 32'd4);
    if (pulse_cyc.size() >= 4) chk("mul_then_add_gap", pulse_cyc[3] - pulse_cyc[2], 32'd1);
    check_regs();

    // MUL with overflow into the high half
    issue(OP_LDI, 0, 0, 1, 8'h10, 8'h10, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_MUL, 1, 1, 5, 8'h00, 8'h00, 1'b1, 1'b1, 1, low_cnt);
    drain();

    // Reset in the middle of a MUL aborts it
    pulse_cyc.delete();
    issue(OP_MUL, 1, 2, 4, 8'h00, 8'h00, 1'b0, 1'b0, 0, low_cnt);
    instr_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("ready_mid_reset", {31'd0, instr_ready}, 32'd0);
    repeat (2) tick();
    chk("ready_held_reset", {31'd0, instr_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_post_abort", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    check_cleared();
    check_regs();
    repeat (DW) tick();
    chk("abort_no_pulse", pulse_cyc.size(), 32'd0);

    // Shifts and NOP
    pulse_cyc.delete();
    issue(OP_LDI, 0, 0, 1, 8'h81, 8'h81, 1'b0, 1'b0, 1, low_cnt);
    issue(OP_SHL, 1, 0, 2, 8'h00, 8'h02, 1'b0, 1'b1, 1, low_cnt);
    issue(OP_SHR, 1, 0, 3, 8'h00, 8'h40, 1'b0, 1'b1, 1, low_cnt);
    issue(OP_NOP, 0, 0, 4, 8'h00, 8'h00, 1'b0, 1'b0, 1, low_cnt);
    drain();
    repeat (3) tick();
    chk("nop_pulses", pulse_cyc.size(), 32'd3);
    chk("nop_result_kept", {24'd0, result}, 32'h40);
    chk("nop_carry_kept", {31'd0, carry_flag}, 32'd1);
    chk("nop_zero_kept", {31'd0, zero_flag}, 32'd0);
    check_regs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
